// File: rtl/ss_display_scanner.sv
// Time-multiplexed seven-segment scan controller: one BCD digit per slot, a
// blanking gap before each lit phase, leading-zero blanking and a per-frame snapshot.
module ss_display_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    blank_lz,
  output logic [3:0]              bin_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int IW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW        = $clog2(REFRESH_DIV + 1);
  localparam int ON_CYCLES = REFRESH_DIV - BLANK_CYCLES;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_ON    = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0][3:0]   snap_q, snap_d;
  logic [NUM_DIGITS-1:0]        sdp_q, sdp_d;
  logic                         wrap_s;
  logic                         lz_s;
  logic                         suppress_s;

  logic [3:0]                   bin_out_q, bin_out_d;
  logic [NUM_DIGITS-1:0]        an_q, an_d;
  logic                         dp_q, dp_d;
  logic                         frame_done_q, frame_done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      snap_q       <= '0;
      sdp_q        <= '0;
      bin_out_q    <= 4'd0;
      an_q         <= '1;
      dp_q         <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      snap_q       <= snap_d;
      sdp_q        <= sdp_d;
      bin_out_q    <= bin_out_d;
      an_q         <= an_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    sdp_d   = sdp_q;
    wrap_s  = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_BLANK;
          idx_d   = '0;
          cnt_d   = '0;
          snap_d  = digits;
          sdp_d   = dp_mask;
        end
        S_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = S_ON;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_ON: begin
          if (cnt_q == ON_LAST) begin
            state_d = S_BLANK;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d  = '0;
              snap_d = digits;
              sdp_d  = dp_mask;
              wrap_s = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next-state values so the registers line up with the FSM state.
  always_comb begin
    lz_s = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      lz_s = lz_s & ~((i >= int'(idx_d)) && (snap_d[i] != 4'd0));
    end
    suppress_s   = blank_lz && (idx_d != '0) && lz_s;
    an_d         = '1;
    dp_d         = 1'b1;
    frame_done_d = wrap_s;
    if (state_d != S_IDLE) begin
      bin_out_d = snap_d[idx_d];
    end else begin
      bin_out_d = bin_out_q;
    end
    if ((state_d == S_ON) && !suppress_s) begin
      an_d[idx_d] = 1'b0;
      dp_d        = ~sdp_d[idx_d];
    end else begin
      an_d = '1;
      dp_d = 1'b1;
    end
  end

  assign bin_out    = bin_out_q;
  assign an         = an_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule
